// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and FSM state type for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  localparam int unsigned BCD_DIGITS = 4;
  localparam int unsigned BCD_W      = 16;
  localparam int unsigned MAX_IN_W   = 13;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD nibble of 5 or more before it is doubled.
module bcd_digit_adj (
  input  logic [3:0] nibble,
  output logic [3:0] adj
);

  always_comb begin
    adj = nibble;
    if (nibble >= 4'd5) begin
      adj = nibble + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// The bcd output register is written only when a conversion completes.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned IN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IN_W-1:0]  bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int unsigned CNT_W = $clog2(IN_W + 1);

  if ((IN_W == 0) || (IN_W > MAX_IN_W)) begin : g_bad_in_w
    $error("bin_to_bcd_seq: IN_W=%0d outside 1..%0d", IN_W, MAX_IN_W);
  end

  state_t                state, state_n;
  logic [BCD_W-1:0]      acc, acc_n, acc_adj;
  logic [BCD_W-1:0]      bcd_n;
  logic [IN_W-1:0]       sh, sh_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  busy_n, done_n;
  logic [BCD_W+IN_W-1:0] shifted;

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .nibble (acc[4*i +: 4]),
      .adj    (acc_adj[4*i +: 4])
    );
  end

  // Corrected accumulator and binary shift register move together as one word;
  // the top corrected bit falls off and the sh MSB enters acc bit 0.
  assign shifted = {acc_adj, sh} << 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
      acc   <= '0;
      sh    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      busy  <= busy_n;
      done  <= done_n;
      bcd   <= bcd_n;
      acc   <= acc_n;
      sh    <= sh_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    busy_n  = busy;
    done_n  = 1'b0;
    bcd_n   = bcd;
    acc_n   = acc;
    sh_n    = sh;
    cnt_n   = cnt;

    unique case (state)
      IDLE: begin
        if (start) begin
          sh_n    = bin;
          acc_n   = '0;
          cnt_n   = CNT_W'(IN_W);
          busy_n  = 1'b1;
          state_n = SHIFT;
        end
      end

      SHIFT: begin
        acc_n = shifted[BCD_W+IN_W-1:IN_W];
        sh_n  = shifted[IN_W-1:0];
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          bcd_n   = shifted[BCD_W+IN_W-1:IN_W];
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq at IN_W=8 and IN_W=13; the monitors pop
// expected results on every done pulse and check value and completion time.
module tb_bin_to_bcd_seq;

  localparam time PERIOD = 10;

  typedef struct {
    logic [15:0] bcd;
    time         t;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start8, start13;
  logic [7:0]  bin8;
  logic [12:0] bin13;
  logic        busy8, done8, busy13, done13;
  logic [15:0] bcd8, bcd13;
  logic [15:0] prev8, prev13;

  exp_t q8[$];
  exp_t q13[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #(PERIOD/2) clk = ~clk;

  bin_to_bcd_seq #(.IN_W(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .start (start8),
    .bin   (bin8),
    .busy  (busy8),
    .done  (done8),
    .bcd   (bcd8)
  );

  bin_to_bcd_seq #(.IN_W(13)) dut13 (
    .clk   (clk),
    .reset (reset),
    .start (start13),
    .bin   (bin13),
    .busy  (busy13),
    .done  (done13),
    .bcd   (bcd13)
  );

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] dec_model(int v);
    return 16'(((v / 1000) % 10) << 12 | ((v / 100) % 10) << 8 |
               ((v / 10) % 10) << 4 | (v % 10));
  endfunction

  // Monitor for the 8-bit instance.
  always @(posedge clk) begin
    time  t;
    exp_t e;
    t = $time;
    #1;
    check("w8_done_busy_excl", done8 & busy8, 0);
    if (done8) begin
      if (q8.size() == 0) begin
        check("w8_spurious_done", done8, 0);
      end else begin
        e = q8.pop_front();
        check("w8_bcd", bcd8, e.bcd);
        check("w8_done_time", t, e.t);
        for (int i = 0; i < 4; i++) check("w8_digit_range", bcd8[4*i +: 4] > 4'd9, 0);
      end
    end else if (!reset) begin
      check("w8_bcd_hold", bcd8, prev8);
    end
    prev8 = bcd8;
  end

  // Monitor for the 13-bit instance.
  always @(posedge clk) begin
    time  t;
    exp_t e;
    t = $time;
    #1;
    check("w13_done_busy_excl", done13 & busy13, 0);
    if (done13) begin
      if (q13.size() == 0) begin
        check("w13_spurious_done", done13, 0);
      end else begin
        e = q13.pop_front();
        check("w13_bcd", bcd13, e.bcd);
        check("w13_done_time", t, e.t);
      end
    end else if (!reset) begin
      check("w13_bcd_hold", bcd13, prev13);
    end
    prev13 = bcd13;
  end

  task automatic wait_idle8();
    int n = 0;
    while (busy8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("w8_idle_timeout", busy8, 0);
  endtask

  task automatic wait_idle13();
    int n = 0;
    while (busy13 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("w13_idle_timeout", busy13, 0);
  endtask

  task automatic convert8(input logic [7:0] v, input logic [15:0] e);
    wait_idle8();
    start8 = 1'b1;
    bin8   = v;
    @(posedge clk);
    q8.push_back('{bcd: e, t: $time + 8 * PERIOD});
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic convert13(input logic [12:0] v, input logic [15:0] e);
    wait_idle13();
    start13 = 1'b1;
    bin13   = v;
    @(posedge clk);
    q13.push_back('{bcd: e, t: $time + 13 * PERIOD});
    @(negedge clk);
    start13 = 1'b0;
  endtask

  initial begin
    #(200000 * PERIOD);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    start8  = 1'b0;
    start13 = 1'b0;
    bin8    = '0;
    bin13   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state held through idle cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_bcd8", bcd8, 16'h0000);
      check("rst_busy8", busy8, 0);
      check("rst_done8", done8, 0);
      check("rst_bcd13", bcd13, 16'h0000);
      check("rst_busy13", busy13, 0);
    end

    // 255 with cycle-by-cycle busy profile, then a long hold.
    wait_idle8();
    start8 = 1'b1;
    bin8   = 8'd255;
    @(posedge clk);
    q8.push_back('{bcd: 16'h0255, t: $time + 8 * PERIOD});
    #1 start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("w8_busy_run", busy8, 1);
      check("w8_no_early_done", done8, 0);
      @(posedge clk);
      #1;
    end
    check("w8_busy_end", busy8, 0);
    check("w8_done_end", done8, 1);
    repeat (20) @(negedge clk);
    check("w8_hold_0255", bcd8, 16'h0255);

    // Directed boundary values.
    convert8(8'd99, 16'h0099);
    convert8(8'd100, 16'h0100);
    convert8(8'd0, 16'h0000);
    convert8(8'd9, 16'h0009);
    convert8(8'd10, 16'h0010);
    convert8(8'd199, 16'h0199);

    // Full sweep against the decimal model.
    for (int v = 0; v < 256; v++) convert8(8'(v), dec_model(v));

    // 13-bit instance.
    convert13(13'd8191, 16'h8191);
    convert13(13'd1000, 16'h1000);
    convert13(13'd999, 16'h0999);
    convert13(13'd4095, 16'h4095);
    convert13(13'd0, 16'h0000);
    wait_idle13();

    // start held high: accepts every IN_W+1 cycles; bin=1 mid-conversion is ignored.
    wait_idle8();
    start8 = 1'b1;
    bin8   = 8'd7;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      q8.push_back('{bcd: (j % 2 == 0) ? 16'h0007 : 16'h0200, t: $time + 8 * PERIOD});
      @(negedge clk);
      bin8 = 8'd1;
      if (j == 3) start8 = 1'b0;
      if (j < 3) begin
        repeat (8) @(negedge clk);
        bin8 = (j % 2 == 0) ? 8'd200 : 8'd7;
      end
    end
    wait_idle8();

    // A start pulse during a conversion must not produce a second result.
    convert8(8'd42, 16'h0042);
    repeat (2) @(negedge clk);
    start8 = 1'b1;
    bin8   = 8'd1;
    @(negedge clk);
    start8 = 1'b0;
    wait_idle8();
    repeat (12) @(negedge clk);
    check("w8_ignored_start_bcd", bcd8, 16'h0042);
    check("w8_ignored_start_q", q8.size(), 0);

    // Reset after three shifts aborts with no done pulse.
    start8 = 1'b1;
    bin8   = 8'd123;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("w8_busy_before_abort", busy8, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("w8_abort_bcd", bcd8, 16'h0000);
    check("w8_abort_busy", busy8, 0);
    check("w8_abort_done", done8, 0);
    repeat (15) @(negedge clk);
    check("w8_abort_busy_later", busy8, 0);
    convert8(8'd5, 16'h0005);
    wait_idle8();
    repeat (3) @(negedge clk);
    check("w8_final_bcd", bcd8, 16'h0005);

    check("q8_drained", q8.size(), 0);
    check("q13_drained", q13.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
